// File: rtl/alu_mul_seq.sv
// Sequential 32x32 -> 64 unsigned shift-and-add multiplier that borrows an external
// 32-bit adder through alu_a/alu_b/alu_ctrl and reads back its result and carry.
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_c
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [5:0]  cnt;
  logic [63:0] acc_next;

  // The ALU carry becomes the new top bit so the 65-bit partial sum survives the shift.
  assign acc_next = {alu_c, alu_result, acc_lo[31:1]};

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  assign alu_ctrl = 3'b000;
  assign alu_a    = busy ? acc_hi : 32'h0;
  assign alu_b    = (busy && acc_lo[0]) ? mcand : 32'h0;

  // NOTE: every register here is state updated on the clock edge, so all writes are
  // non-blocking; blocking writes would let later statements see same-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= 32'h0;
      acc_hi  <= 32'h0;
      acc_lo  <= 32'h0;
      cnt     <= 6'd0;
      product <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if ((op_a != 32'h0) && (op_b != 32'h0)) begin
              mcand  <= op_a;
              acc_hi <= 32'h0;
              acc_lo <= op_b;
              cnt    <= 6'd0;
              state  <= RUN;
            end else begin
              // A zero operand skips the iteration entirely.
              product <= 64'h0;
              state   <= DONE;
            end
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= acc_next;
          cnt              <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            product <= acc_next;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: models the external adder, checks a vector table,
// randomized products against plain 64-bit arithmetic, and the start/reset corner cases.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_c;

  int errors = 0;
  int checks = 0;

  // Operands the DUT is expected to be working on; used by the per-cycle monitor.
  logic [31:0] cur_a = 32'h0;
  logic [31:0] cur_b = 32'h0;
  bit          mon_en = 1'b0;

  alu_mul_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_c      (alu_c)
  );

  // External ALU: plain 32-bit add with carry out.
  assign {alu_c, alu_result} = 33'(alu_a) + 33'(alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle interface checks. The expected accumulator high half after k steps is
  // the product of the multiplicand with the low k multiplier bits, shifted down by k.
  int step = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("alu_ctrl", 64'(alu_ctrl), 64'd0);
      check("one_hot_status", 64'(int'(ready) + int'(busy) + int'(done)), 64'd1);
      if (busy) begin
        logic [63:0] mask;
        logic [63:0] partial;
        mask    = (64'd1 << step) - 64'd1;
        partial = (64'(cur_a) * (64'(cur_b) & mask)) >> step;
        check("run_alu_b", 64'(alu_b), cur_b[step[4:0]] ? 64'(cur_a) : 64'd0);
        check("run_alu_a", 64'(alu_a), 64'(partial[31:0]));
        step++;
      end else begin
        check("idle_alu_a", 64'(alu_a), 64'd0);
        check("idle_alu_b", 64'(alu_b), 64'd0);
        step = 0;
      end
    end
  end

  // Waits (bounded) for the done pulse; n counts cycles spent waiting.
  task automatic wait_done(output int n, output int busy_cycles, output bit got);
    n = 0;
    busy_cycles = 0;
    got = 1'b0;
    while (n < 40) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      tick();
      n++;
    end
  endtask

  // Presents one start pulse from IDLE, scrambles the operands after acceptance and
  // returns at the DONE cycle with latency measured from the start cycle.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cycles,
                        output logic [63:0] prod, output bit got, output bit held);
    logic [63:0] prev;
    int n;
    prev  = product;
    held  = 1'b1;
    op_a  = a;
    op_b  = b;
    cur_a = a;
    cur_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    lat   = 1;
    busy_cycles = 0;
    got   = 1'b0;
    n     = 0;
    while (n < 40) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (product !== prev) held = 1'b0;
      tick();
      lat++;
      n++;
    end
    prod = product;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_prod;
    bit          early;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int lat;
    int bc;
    int n;
    bit got;
    bit held;
    bit saw_done;
    logic [63:0] prod;

    vecs[0]  = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
    vecs[2]  = '{32'h0000_0000, 32'h0000_1234, 64'h0, 1'b1};
    vecs[3]  = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0};
    vecs[4]  = '{32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b0};
    vecs[6]  = '{32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001, 1'b0};
    vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[8]  = '{32'h1234_5678, 32'h0000_0000, 64'h0, 1'b1};
    vecs[9]  = '{32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 1'b0};
    vecs[10] = '{32'h8000_0001, 32'h8000_0001, 64'h4000_0001_0000_0001, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    op_a  = 32'h0;
    op_b  = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", product, 64'd0);
    mon_en = 1'b1;

    // Idle with start low holds everything.
    tick();
    tick();
    check("idle_hold_ready", 64'(ready), 64'd1);
    check("idle_hold_product", product, 64'd0);

    for (int i = 0; i < 11; i++) begin
      do_mul(vecs[i].a, vecs[i].b, lat, bc, prod, got, held);
      check($sformatf("vec%0d_done", i), 64'(got), 64'd1);
      check($sformatf("vec%0d_product", i), prod, vecs[i].exp_prod);
      check($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].early ? 64'd1 : 64'd33);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), vecs[i].early ? 64'd0 : 64'd32);
      check($sformatf("vec%0d_product_held", i), 64'(held), 64'd1);
      tick();
      check($sformatf("vec%0d_back_idle", i), 64'(ready), 64'd1);
      check($sformatf("vec%0d_product_kept", i), product, vecs[i].exp_prod);
    end

    // Randomized operands against 64-bit arithmetic, back-to-back at minimum period.
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      do_mul(a, b, lat, bc, prod, got, held);
      check($sformatf("rand%0d_product", i), prod, 64'(a) * 64'(b));
      check($sformatf("rand%0d_latency", i), 64'(lat), (a == 0 || b == 0) ? 64'd1 : 64'd33);
      tick();
    end

    // start during RUN and DONE is ignored; next IDLE start is accepted.
    op_a  = 32'd7;
    op_b  = 32'd6;
    cur_a = 32'd7;
    cur_b = 32'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    op_a  = 32'd9;
    op_b  = 32'd9;
    start = 1'b1;
    check("ignore_run_ready", 64'(ready), 64'd0);
    tick();
    start = 1'b0;
    wait_done(n, bc, got);
    check("ignore_run_done", 64'(got), 64'd1);
    check("ignore_run_product", product, 64'h2A);
    start = 1'b1;
    tick();
    check("ignore_done_idle", 64'(ready), 64'd1);
    check("ignore_done_busy", 64'(busy), 64'd0);
    cur_a = 32'd9;
    cur_b = 32'd9;
    tick();
    start = 1'b0;
    check("next_idle_accept", 64'(busy), 64'd1);
    wait_done(n, bc, got);
    check("next_idle_product", product, 64'd81);
    tick();

    // Reset mid-RUN discards the operation without a done pulse.
    op_a  = 32'h8000_0000;
    op_b  = 32'h0000_0002;
    cur_a = op_a;
    cur_b = op_b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("midrun_reset_ready", 64'(ready), 64'd1);
    check("midrun_reset_busy", 64'(busy), 64'd0);
    check("midrun_reset_done", 64'(done), 64'd0);
    check("midrun_reset_product", product, 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      tick();
    end
    check("midrun_reset_no_done", 64'(saw_done), 64'd0);
    do_mul(32'h8000_0000, 32'h0000_0002, lat, bc, prod, got, held);
    check("restart_product", prod, 64'h0000_0001_0000_0000);
    check("restart_latency", 64'(lat), 64'd33);
    tick();

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 No parameters; operand width SHALL be fixed at 32 bits, product width at 64 bits.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only when ready=1.
REQ-005 op_a  input  32  multiplicand, unsigned; captured when start is accepted.
REQ-006 op_b  input  32  multiplier, unsigned; captured when start is accepted.
REQ-007 ready  output  1  high iff state=IDLE.
REQ-008 busy  output  1  high iff state=RUN.
REQ-009 done  output  1  one-cycle pulse, high iff state=DONE.
REQ-010 product  output  64  result register; holds the last completed product until the next completion.
REQ-011 alu_a  output  32  drives A of the shared 32-bit ALU.
REQ-012 alu_b  output  32  drives B of the shared ALU.
REQ-013 alu_ctrl  output  3  drives ALUControl; SHALL be 3'b000 (add) at all times.
REQ-014 alu_result  input  32  ALU Result.
REQ-015 alu_c  input  1  ALU carry flag C (carry-out of the add).

Function
REQ-016 States SHALL be IDLE, RUN, DONE; internal regs: mcand[31:0], acc_hi[31:0], acc_lo[31:0], cnt[5:0].
REQ-017 IDLE with start=1 and op_a!=0 and op_b!=0: load mcand=op_a, acc_hi=0, acc_lo=op_b, cnt=0; next state RUN.
REQ-018 IDLE with start=1 and (op_a==0 or op_b==0): early-out; product<=0, next state DONE (no RUN cycles).
REQ-019 IDLE with start=0: remain IDLE; no register change.
REQ-020 In RUN: alu_a=acc_hi, alu_b=(acc_lo[0] ? mcand : 32'h0), alu_ctrl=3'b000.
REQ-021 In RUN, each edge: {acc_hi, acc_lo} <= {alu_c, alu_result, acc_lo[31:1]}; cnt <= cnt+1.
REQ-022 RUN SHALL last exactly 32 cycles; on the edge where cnt==31: product <= next {acc_hi, acc_lo}, next state DONE.
REQ-023 DONE SHALL last exactly one cycle, then IDLE unconditionally; start during DONE SHALL be ignored.
REQ-024 start during RUN or DONE SHALL be ignored; op_a/op_b changes outside acceptance SHALL not affect the result.
REQ-025 Outside RUN: alu_a=0, alu_b=0, alu_ctrl=3'b000.
REQ-026 Latency: start accepted at edge E0 -> done high in the cycle after E32 (33 cycles after the start cycle); early-out -> done high in the cycle after E0.
REQ-027 Throughput: a new start SHALL be accepted in the first IDLE cycle after DONE (34-cycle minimum period for non-zero operands).
REQ-028 Carry from the ALU SHALL be retained each step so that the full 64-bit product is exact for all operand values, including 32'hFFFFFFFF.
REQ-029 product SHALL change only on entry to DONE or on reset.

Reset
REQ-030 rst=1 at any edge, including mid-RUN: state<=IDLE, cnt<=0, mcand/acc_hi/acc_lo<=0, product<=0; done=0, busy=0, ready=1 in the following cycle.
REQ-031 rst SHALL take priority over start in the same cycle; an in-flight operation is discarded with no done pulse.

Verification
REQ-032 op_a=3, op_b=5, start 1 cycle -> busy 32 cycles, done pulse 33 cycles after start, product=64'h0000_0000_0000_000F.
REQ-033 op_a=op_b=32'hFFFFFFFF -> product=64'hFFFF_FFFE_0000_0001 (exercises alu_c every step).
REQ-034 op_a=0, op_b=32'h1234 -> no busy, done in the next cycle, product=0; then op_a=32'h10000, op_b=32'h10000 -> product=64'h0000_0001_0000_0000.
REQ-035 op_a=7, op_b=6 accepted; at RUN cycle 5 assert start with op_a=9, op_b=9 -> ignored, product=42 (0x2A); DONE cycle start ignored; next IDLE start accepted.
REQ-036 op_a=32'h8000_0000, op_b=2 started; rst at RUN cycle 10 -> IDLE, product=0, no done; restart op_a=32'h8000_0000, op_b=2 -> product=64'h0000_0001_0000_0000.
REQ-037 Check every cycle: alu_ctrl=000; in RUN alu_b is mcand or 0 per acc_lo[0]; outside RUN alu_a=alu_b=0.
